irq_collector: RTL and testbench

- Upstream stage of the 8-to-3 priority encoder path.
- Turns raw request lines into latched pending flags and applies per-source masks.
- Picks the highest-index pending source and presents its ID to a consumer through a registered valid/ready handshake.
- The pending flag is cleared on acceptance.

---
 rtl/irqc_pkg.sv | 12 +
 rtl/irqc_pri_enc.sv | 25 ++
 rtl/irq_collector.sv | 118 +++++++++++
 tb/tb_irq_collector.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/irqc_pkg.sv
// Shared constants and state encoding for the interrupt collector.
package irqc_pkg;

    localparam int IRQC_N   = 8;
    localparam int IRQC_IDW = 3;

    typedef enum logic {
        IDLE,
        PRESENT
    } irqc_state_t;

endpackage

// File: rtl/irqc_pri_enc.sv
// Combinational N-to-IDW priority encoder; the highest set index wins.
module irqc_pri_enc
    import irqc_pkg::*;
#(
    parameter int N   = IRQC_N,
    parameter int IDW = IRQC_IDW
) (
    input  logic [N-1:0]   req_i,
    output logic [IDW-1:0] id_o,
    output logic           any_o
);

    // Ascending scan so a later (higher) index overrides a lower one.
    always_comb begin
        id_o  = '0;
        any_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req_i[i]) begin
                id_o  = IDW'(i);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_collector.sv
// Edge-latched interrupt collector with masking, priority pick and a registered
// valid/ready output. Optional sticky overflow flags under IRQ_COLLECTOR_OVERFLOW_EN.
module irq_collector
    import irqc_pkg::*;
#(
    parameter int N   = IRQC_N,
    parameter int IDW = IRQC_IDW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_in,
    input  logic [N-1:0]   mask,
    output logic           irq_valid,
    output logic [IDW-1:0] irq_id,
    input  logic           irq_ready,
    output logic [N-1:0]   pending_out
`ifdef IRQ_COLLECTOR_OVERFLOW_EN
    ,
    output logic [N-1:0]   ovf,
    input  logic           ovf_clr
`endif
);

    irqc_state_t    state_q, state_d;
    logic [N-1:0]   req_prev_q;
    logic [N-1:0]   pending_q, pending_d;
    logic           valid_q, valid_d;
    logic [IDW-1:0] id_q, id_d;

    logic [N-1:0]   edge_w;
    logic [N-1:0]   eligible_w;
    logic [N-1:0]   clr_vec_w;
    logic [IDW-1:0] winner_w;
    logic           any_w;
    logic           accept_w;

    assign edge_w     = req_in & ~req_prev_q;
    assign eligible_w = pending_q & mask;

    // Handshake: a transfer happens on any edge where irq_valid && irq_ready;
    // irq_valid/irq_id are registered and never change while waiting for ready.
    assign accept_w  = (state_q == PRESENT) && irq_ready;
    assign clr_vec_w = accept_w ? (N'(1) << id_q) : '0;
    assign pending_d = (pending_q & ~clr_vec_w) | edge_w;

    irqc_pri_enc #(
        .N   (N),
        .IDW (IDW)
    ) u_pri_enc (
        .req_i (eligible_w),
        .id_o  (winner_w),
        .any_o (any_w)
    );

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        id_d    = id_q;
        unique case (state_q)
            IDLE: begin
                if (any_w) begin
                    id_d    = winner_w;
                    valid_d = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (irq_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            req_prev_q <= '0;
            pending_q  <= '0;
            valid_q    <= 1'b0;
            id_q       <= '0;
        end else begin
            state_q    <= state_d;
            req_prev_q <= req_in;
            pending_q  <= pending_d;
            valid_q    <= valid_d;
            id_q       <= id_d;
        end
    end

    assign irq_valid   = valid_q;
    assign irq_id      = id_q;
    assign pending_out = pending_q;

`ifdef IRQ_COLLECTOR_OVERFLOW_EN
    logic [N-1:0] ovf_q, ovf_d;

    // A re-arrival on a still-pending bit overflows unless that bit is being
    // consumed this very cycle; a fresh overflow beats a simultaneous clear.
    assign ovf_d = (ovf_clr ? '0 : ovf_q) | (edge_w & pending_q & ~clr_vec_w);

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_irq_collector.sv
// Cycle-by-cycle vector table plus a randomised backpressure sequence for irq_collector.
module tb_irq_collector;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req_in;
    logic [7:0] mask;
    logic       irq_valid;
    logic [2:0] irq_id;
    logic       irq_ready;
    logic [7:0] pending_out;
    logic       oclr;
`ifdef IRQ_COLLECTOR_OVERFLOW_EN
    logic [7:0] ovf;
`endif

    always #5 clk = ~clk;

    irq_collector dut (
        .clk         (clk),
        .rst         (rst),
        .req_in      (req_in),
        .mask        (mask),
        .irq_valid   (irq_valid),
        .irq_id      (irq_id),
        .irq_ready   (irq_ready),
        .pending_out (pending_out)
`ifdef IRQ_COLLECTOR_OVERFLOW_EN
        ,
        .ovf         (ovf),
        .ovf_clr     (oclr)
`endif
    );

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [7:0] mask;
        logic       rdy;
        logic       oclr;
        logic       ev;
        logic [2:0] eid;
        logic [7:0] ep;
        logic [7:0] eo;
    } vec_t;

    vec_t        vecs[$];
    logic [11:0] exp_q[$];
    logic [7:0]  exp_ovf_q[$];
    int          checks = 0;
    int          errors = 0;

    function automatic vec_t mk(logic r, logic [7:0] q, logic [7:0] m, logic rd, logic oc,
                                logic v, logic [2:0] id, logic [7:0] p, logic [7:0] o);
        vec_t t;
        t.rst = r; t.req = q; t.mask = m; t.rdy = rd; t.oclr = oc;
        t.ev = v; t.eid = id; t.ep = p; t.eo = o;
        return t;
    endfunction

    task automatic drive(input vec_t t);
        @(negedge clk);
        rst       = t.rst;
        req_in    = t.req;
        mask      = t.mask;
        irq_ready = t.rdy;
        oclr      = t.oclr;
        exp_q.push_back({t.ev, t.eid, t.ep});
        exp_ovf_q.push_back(t.eo);
    endtask

    task automatic check_out(input string name);
        logic [11:0] e;
        logic [11:0] a;
        logic [7:0]  eo;
        e  = exp_q.pop_front();
        eo = exp_ovf_q.pop_front();
        a  = {irq_valid, irq_id, pending_out};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got valid=%0b id=%0d pending=%h, expected valid=%0b id=%0d pending=%h",
                     name, a[11], a[10:8], a[7:0], e[11], e[10:8], e[7:0]);
        end
`ifdef IRQ_COLLECTOR_OVERFLOW_EN
        checks++;
        if (ovf !== eo) begin
            errors++;
            $display("FAIL %s_ovf: got ovf=%h, expected %h", name, ovf, eo);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hold;
        int waited;
        bit seen;
        rst = 1'b1; req_in = '0; mask = 8'hFF; irq_ready = 1'b0; oclr = 1'b0;

        //            rst req    mask   rdy clr  v  id p      ovf
        vecs.push_back(mk(1, 8'h00, 8'hFF, 0, 0, 0, 0, 8'h00, 8'h00)); // 0 reset
        vecs.push_back(mk(0, 8'h00, 8'hFF, 0, 0, 0, 0, 8'h00, 8'h00));
        vecs.push_back(mk(0, 8'h04, 8'hFF, 0, 0, 0, 0, 8'h04, 8'h00)); // 2 single edge
        vecs.push_back(mk(0, 8'h04, 8'hFF, 0, 0, 1, 2, 8'h04, 8'h00));
        vecs.push_back(mk(0, 8'h04, 8'hFF, 1, 0, 0, 2, 8'h00, 8'h00));
        vecs.push_back(mk(0, 8'h00, 8'hFF, 0, 0, 0, 2, 8'h00, 8'h00));
        vecs.push_back(mk(0, 8'h81, 8'hFF, 1, 0, 0, 2, 8'h81, 8'h00)); // 6 priority
        vecs.push_back(mk(0, 8'h81, 8'hFF, 1, 0, 1, 7, 8'h81, 8'h00));
        vecs.push_back(mk(0, 8'h81, 8'hFF, 1, 0, 0, 7, 8'h01, 8'h00));
        vecs.push_back(mk(0, 8'h81, 8'hFF, 1, 0, 1, 0, 8'h01, 8'h00));
        vecs.push_back(mk(0, 8'h81, 8'hFF, 1, 0, 0, 0, 8'h00, 8'h00));
        vecs.push_back(mk(0, 8'h00, 8'hFF, 0, 0, 0, 0, 8'h00, 8'h00));
        vecs.push_back(mk(0, 8'h80, 8'h7F, 0, 0, 0, 0, 8'h80, 8'h00)); // 12 masking
        vecs.push_back(mk(0, 8'h80, 8'h7F, 0, 0, 0, 0, 8'h80, 8'h00));
        vecs.push_back(mk(0, 8'h80, 8'h7F, 0, 0, 0, 0, 8'h80, 8'h00));
        vecs.push_back(mk(0, 8'h80, 8'hFF, 0, 0, 1, 7, 8'h80, 8'h00));
        vecs.push_back(mk(0, 8'h00, 8'hFF, 1, 0, 0, 7, 8'h00, 8'h00));
        vecs.push_back(mk(0, 8'h20, 8'hFF, 0, 0, 0, 7, 8'h20, 8'h00)); // 17 backpressure
        vecs.push_back(mk(0, 8'h20, 8'hFF, 0, 0, 1, 5, 8'h20, 8'h00));
        vecs.push_back(mk(0, 8'h60, 8'hFF, 0, 0, 1, 5, 8'h60, 8'h00));
        vecs.push_back(mk(0, 8'h60, 8'hFF, 0, 0, 1, 5, 8'h60, 8'h00));
        vecs.push_back(mk(0, 8'h60, 8'h00, 0, 0, 1, 5, 8'h60, 8'h00));
        vecs.push_back(mk(0, 8'h60, 8'h1F, 0, 0, 1, 5, 8'h60, 8'h00));
        vecs.push_back(mk(0, 8'h60, 8'hFF, 0, 0, 1, 5, 8'h60, 8'h00));
        vecs.push_back(mk(0, 8'h60, 8'hFF, 1, 0, 0, 5, 8'h40, 8'h00));
        vecs.push_back(mk(0, 8'h60, 8'hFF, 0, 0, 1, 6, 8'h40, 8'h00));
        vecs.push_back(mk(0, 8'h00, 8'hFF, 1, 0, 0, 6, 8'h00, 8'h00));
        vecs.push_back(mk(0, 8'h08, 8'hFF, 0, 0, 0, 6, 8'h08, 8'h00)); // 27 collision
        vecs.push_back(mk(0, 8'h00, 8'hFF, 0, 0, 1, 3, 8'h08, 8'h00));
        vecs.push_back(mk(0, 8'h08, 8'hFF, 1, 0, 0, 3, 8'h08, 8'h00));
        vecs.push_back(mk(0, 8'h08, 8'hFF, 0, 0, 1, 3, 8'h08, 8'h00));
        vecs.push_back(mk(0, 8'h00, 8'hFF, 0, 0, 1, 3, 8'h08, 8'h00));
        vecs.push_back(mk(0, 8'h08, 8'hFF, 0, 0, 1, 3, 8'h08, 8'h08)); // overflow
        vecs.push_back(mk(0, 8'h00, 8'hFF, 0, 1, 1, 3, 8'h08, 8'h00));
        vecs.push_back(mk(0, 8'h00, 8'hFF, 1, 0, 0, 3, 8'h00, 8'h00));
        vecs.push_back(mk(0, 8'h04, 8'hFF, 0, 0, 0, 3, 8'h04, 8'h00)); // 35 ovf set beats clear
        vecs.push_back(mk(0, 8'h00, 8'hFF, 0, 0, 1, 2, 8'h04, 8'h00));
        vecs.push_back(mk(0, 8'h04, 8'hFF, 0, 1, 1, 2, 8'h04, 8'h04));
        vecs.push_back(mk(0, 8'h04, 8'hFF, 1, 0, 0, 2, 8'h00, 8'h04));
        vecs.push_back(mk(0, 8'h00, 8'hFF, 0, 1, 0, 2, 8'h00, 8'h00));
        vecs.push_back(mk(0, 8'h30, 8'hFF, 0, 0, 0, 2, 8'h30, 8'h00)); // 40 mid reset
        vecs.push_back(mk(0, 8'h30, 8'hFF, 0, 0, 1, 5, 8'h30, 8'h00));
        vecs.push_back(mk(1, 8'h01, 8'hFF, 0, 0, 0, 0, 8'h00, 8'h00));
        vecs.push_back(mk(0, 8'h01, 8'hFF, 0, 0, 0, 0, 8'h01, 8'h00));
        vecs.push_back(mk(0, 8'h01, 8'hFF, 0, 0, 1, 0, 8'h01, 8'h00));
        vecs.push_back(mk(0, 8'h01, 8'hFF, 1, 0, 0, 0, 8'h00, 8'h00));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check_out($sformatf("row%0d", i));
        end

        // Randomised-length stall: presented ID must not move until accepted.
        drive(mk(0, 8'h10, 8'hFF, 0, 0, 0, 0, 8'h10, 8'h00));
        @(posedge clk);
        #1;
        check_out("stall_edge");
        exp_q.push_back({1'b1, 3'd4, 8'h10});
        exp_ovf_q.push_back(8'h00);
        seen = 1'b0;
        waited = 0;
        while (!seen && waited < 6) begin
            @(posedge clk);
            #1;
            waited++;
            seen = irq_valid;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL stall_wait: got irq_valid=0 after %0d cycles, expected 1", waited);
            void'(exp_q.pop_front());
            void'(exp_ovf_q.pop_front());
        end else begin
            check_out("stall_present");
        end
        hold = $urandom_range(1, 8);
        for (int k = 0; k < hold; k++) begin
            drive(mk(0, 8'h10, ((k % 2) == 0) ? 8'h00 : 8'hFF, 0, 0, 1, 4, 8'h10, 8'h00));
            @(posedge clk);
            #1;
            check_out($sformatf("stall_hold%0d", k));
        end
        drive(mk(0, 8'h10, 8'hFF, 1, 0, 0, 4, 8'h00, 8'h00));
        @(posedge clk);
        #1;
        check_out("stall_accept");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
